// File: rtl/clock_div_multi_pkg.sv
// Shared definitions for the multi-channel clock divider.
package clock_div_multi_pkg;

    localparam int unsigned DEFAULT_DIV_RESET = 2;

    // Select width for a channel index, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        ChIdle,
        ChBypass,
        ChCount
    } chan_mode_t;

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: period counter, active/pending ratio and registered enable.
module clock_div_chan
    import clock_div_multi_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_RESET
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic             div_out,
    output logic             tick,
    output logic             pend
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] pend_n_q, pend_n_d;
    logic             pend_q, pend_d;
    logic             en_q;

    chan_mode_t       mode;
    logic [WIDTH-1:0] half;
    logic             wrap;
    logic             boundary;

    always_comb begin
        if (!en_q) begin
            mode = ChIdle;
        end else if (act_q < WIDTH'(2)) begin
            mode = ChBypass;
        end else begin
            mode = ChCount;
        end
    end

    // ceil(act_n / 2): odd ratios spend the extra cycle high.
    assign half = (act_q >> 1) + {{(WIDTH-1){1'b0}}, act_q[0]};

    assign tick    = (mode != ChIdle) && (cnt_q == '0);
    assign div_out = (mode == ChBypass) || ((mode == ChCount) && (cnt_q < half));
    assign pend    = pend_q;

    // Idle cycles count as boundaries so a pending ratio never survives a disable.
    assign wrap     = (mode == ChBypass) || ((mode == ChCount) && (cnt_q == act_q - WIDTH'(1)));
    assign boundary = (mode == ChIdle) || wrap || sync;

    always_comb begin
        cnt_d    = '0;
        act_d    = act_q;
        pend_n_d = pend_n_q;
        pend_d   = pend_q;

        if (en && (mode != ChIdle) && !boundary) begin
            cnt_d = cnt_q + WIDTH'(1);
        end

        if (boundary && pend_q) begin
            act_d  = pend_n_q;
            pend_d = 1'b0;
        end

        if (we) begin
            if (mode == ChIdle) begin
                act_d  = wdata;
                pend_d = 1'b0;
            end else begin
                pend_n_d = wdata;
                pend_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            act_q    <= WIDTH'(DEFAULT_DIV);
            pend_n_q <= '0;
            pend_q   <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            pend_n_q <= pend_n_d;
            pend_q   <= pend_d;
            en_q     <= en;
        end
    end

endmodule

// File: rtl/clock_div_multi.sv
// Bank of independent clock dividers sharing one ratio-write port and a sync pulse.
module clock_div_multi
    import clock_div_multi_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_RESET,
    localparam int unsigned SELW       = sel_width(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic             cfg_we,
    input  logic [SELW-1:0]  cfg_sel,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             sync,
    output logic [NCH-1:0]   div_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pend
);

    // Out-of-range selects match no channel and are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic we_ch;
        assign we_ch = cfg_we && (32'(cfg_sel) == 32'(i));

        clock_div_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (en[i]),
            .sync    (sync),
            .we      (we_ch),
            .wdata   (cfg_div),
            .div_out (div_out[i]),
            .tick    (tick[i]),
            .pend    (pend[i])
        );
    end

endmodule

// File: doc/clock_div_multi.md
CLOCK_DIV_MULTI -- requirements
Module: clock_div_multi

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 8: bits per divide ratio.
REQ-003 SHALL have parameter DEFAULT_DIV, default 2: ratio loaded into every channel at reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  NCH  per-channel run enable.
REQ-007 SHALL have port cfg_we  input  1  single-cycle ratio write strobe.
REQ-008 SHALL have port cfg_sel  input  clog2(NCH) (min 1)  target channel of the write.
REQ-009 SHALL have port cfg_div  input  WIDTH  new divide ratio N.
REQ-010 SHALL have port sync  input  1  phase-align pulse for all channels.
REQ-011 SHALL have port div_out  output  NCH  divided square waves.
REQ-012 SHALL have port tick  output  NCH  one-cycle period-start strobes.
REQ-013 SHALL have port pend  output  NCH  ratio-change-pending flags.

Function
REQ-014 Each channel SHALL hold registers cnt (WIDTH), act_n (WIDTH), pend_n (WIDTH), pend flag.
REQ-015 Outputs SHALL depend only on registered state; no combinational path from any input to any output.
REQ-016 Enabled channel, act_n >= 2: cnt counts 0..act_n-1 then wraps to 0; period = act_n cycles.
REQ-017 tick[i] SHALL equal en_q[i] & (cnt==0), en_q being en registered one cycle.
REQ-018 div_out[i] SHALL be 1 while cnt < ceil(act_n/2), else 0; odd N gives one extra high cycle (N=5: 3 high, 2 low).
REQ-019 act_n of 0 or 1 SHALL be divide-by-1: cnt held 0, tick=1 and div_out=1 every enabled cycle.
REQ-020 A disabled channel SHALL hold cnt=0, drive tick=0 and div_out=0; on re-enable the first output cycle has tick=1.
REQ-021 cfg_we with channel cfg_sel enabled SHALL write pend_n and set pend; a later write before the boundary overwrites it (last wins).
REQ-022 At a period boundary (cnt wrap, or every cycle for divide-by-1) with pend set: act_n <= pend_n, pend cleared, cnt <= 0; no short or runt period.
REQ-023 cfg_we landing on a boundary cycle: the previously pending value applies now; the new value becomes pending for the next boundary.
REQ-024 cfg_we to a disabled channel SHALL load act_n directly, leave pend clear, keep cnt=0.
REQ-025 cfg_sel >= NCH SHALL be ignored.
REQ-026 sync=1 SHALL force cnt<=0 on all enabled channels next cycle, applying any pending ratio as a boundary; simultaneous sync and cfg_we behaves as REQ-023.
REQ-027 pend[i] SHALL mirror the pend flag.

Reset
REQ-028 Reset SHALL set cnt=0, act_n=DEFAULT_DIV, pend_n=0, pend=0, en_q=0; all outputs 0 in the cycle after reset is sampled.
REQ-029 Reset SHALL take priority over sync, cfg_we and en; reset mid-period abandons the period.

Structure
REQ-030 Package clock_div_multi_pkg SHALL hold the DEFAULT_DIV default, the clog2 select-width function and the channel-state typedef.
REQ-031 Per-channel logic SHALL be one sub-module clock_div_chan, instantiated NCH times by generate; the top holds only write decode and sync fan-out.

Verification
REQ-032 Reset, en=4'b0001 -> ch0 period 2: tick 1,0,1,0..., div_out 1,0,1,0...
REQ-033 ch1 N=5 enabled -> tick every 5 cycles, div_out 3 high/2 low, repeat 20 periods.
REQ-034 ch0 running N=4; write 7 at cnt=1 then 3 at cnt=2 -> pend=1, current period completes at 4 cycles, next periods 3 cycles, pend=0.
REQ-035 N=1 and N=0 writes to disabled ch2, then enable -> tick and div_out high every cycle.
REQ-036 ch0 N=3, ch1 N=4 free-running; pulse sync -> both tick in the same cycle after sync.
REQ-037 Reset asserted mid-period with pend set -> all outputs 0, pend 0, after release period = DEFAULT_DIV.
